// File: rtl/axi_sched_pkg.sv
// Shared types and default sizes for the AXI write-route scheduler.
package axi_sched_pkg;

    localparam int DEF_M_WIDTH = 2;
    localparam int DEF_S_WIDTH = 3;
    localparam int DEF_DEPTH   = 4;

    typedef enum logic {
        AW_IDLE  = 1'b0,
        AW_GRANT = 1'b1
    } aw_state_e;

endpackage

// File: rtl/axi_route_fifo.sv
// In-order route queue: register-based FIFO with a fall-through head, fully async-reset.
module axi_route_fifo
    import axi_sched_pkg::*;
#(
    parameter int WIDTH = DEF_M_WIDTH + DEF_S_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign count   = count_reg;
    assign dout    = mem_reg[rd_ptr_reg];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage is reset too so the head outputs read 0 while the queue is empty after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                mem_reg[wr_ptr_reg] <= din;
                wr_ptr_reg          <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_wr_route_scheduler.sv
// Round-robin AW arbiter plus in-order route queue that steers W data in AW acceptance order.
module axi_wr_route_scheduler
    import axi_sched_pkg::*;
#(
    parameter int M_WIDTH = DEF_M_WIDTH,
    parameter int S_WIDTH = DEF_S_WIDTH,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [2**M_WIDTH-1:0]        m_awvalid,
    input  logic [2**M_WIDTH*S_WIDTH-1:0] m_aw_slave,
    input  logic                         bus_awready,
    output logic                         aw_grant_valid,
    output logic [M_WIDTH-1:0]           aw_master_sel,
    output logic [S_WIDTH-1:0]           aw_slave_sel,
    input  logic                         bus_wvalid,
    input  logic                         bus_wready,
    input  logic                         bus_wlast,
    output logic                         w_route_valid,
    output logic [M_WIDTH-1:0]           wr_data_master_sel,
    output logic [S_WIDTH-1:0]           wr_data_slave_sel,
    output logic [$clog2(DEPTH):0]       outstanding,
    output logic                         w_orphan_err
);

    localparam int NM = 2 ** M_WIDTH;
    localparam int RW = M_WIDTH + S_WIDTH;

    typedef struct packed {
        logic [M_WIDTH-1:0] m;
        logic [S_WIDTH-1:0] s;
    } wr_route_t;

    aw_state_e          state_reg;
    logic               grant_valid_reg;
    logic [M_WIDTH-1:0] master_sel_reg;
    logic [S_WIDTH-1:0] slave_sel_reg;
    logic [M_WIDTH-1:0] rr_ptr_reg;
    logic               orphan_reg;

    logic [S_WIDTH-1:0] slave_arr [NM];
    logic               win_found;
    logic [M_WIDTH-1:0] win_idx;
    logic [M_WIDTH-1:0] rr_cand;

    wr_route_t          push_route;
    wr_route_t          head_route;
    logic [RW-1:0]      head_bits;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push;
    logic               pop;
    logic               w_hs;

    generate
        for (genvar gi = 0; gi < NM; gi++) begin : g_slave_slice
            assign slave_arr[gi] = m_aw_slave[gi*S_WIDTH +: S_WIDTH];
        end
    endgenerate

    // First requester at or after the RR pointer, wrapping modulo NM.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr_reg;
        rr_cand   = '0;
        for (int k = 0; k < NM; k++) begin
            rr_cand = rr_ptr_reg + M_WIDTH'(k);
            if (!win_found && m_awvalid[rr_cand]) begin
                win_found = 1'b1;
                win_idx   = rr_cand;
            end
        end
    end

    assign push       = grant_valid_reg & bus_awready;
    assign w_hs       = bus_wvalid & bus_wready;
    assign pop        = w_hs & bus_wlast & ~fifo_empty;
    assign push_route = '{m: master_sel_reg, s: slave_sel_reg};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= AW_IDLE;
            grant_valid_reg <= 1'b0;
            master_sel_reg  <= '0;
            slave_sel_reg   <= '0;
            rr_ptr_reg      <= '0;
            orphan_reg      <= 1'b0;
        end else begin
            orphan_reg <= w_hs & fifo_empty;
            case (state_reg)
                AW_IDLE: begin
                    if (win_found && !fifo_full) begin
                        grant_valid_reg <= 1'b1;
                        master_sel_reg  <= win_idx;
                        slave_sel_reg   <= slave_arr[win_idx];
                        state_reg       <= AW_GRANT;
                    end
                end
                AW_GRANT: begin
                    // Grant is frozen regardless of request changes until the slave accepts.
                    if (bus_awready) begin
                        grant_valid_reg <= 1'b0;
                        rr_ptr_reg      <= master_sel_reg + 1'b1;
                        state_reg       <= AW_IDLE;
                    end
                end
                default: begin
                    grant_valid_reg <= 1'b0;
                    state_reg       <= AW_IDLE;
                end
            endcase
        end
    end

    axi_route_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_route_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .din   (push_route),
        .dout  (head_bits),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (outstanding)
    );

    assign head_route         = wr_route_t'(head_bits);
    assign aw_grant_valid     = grant_valid_reg;
    assign aw_master_sel      = master_sel_reg;
    assign aw_slave_sel       = slave_sel_reg;
    assign w_route_valid      = ~fifo_empty;
    assign wr_data_master_sel = head_route.m;
    assign wr_data_slave_sel  = head_route.s;
    assign w_orphan_err       = orphan_reg;

endmodule

// File: tb/tb_axi_wr_route_scheduler.sv
// Directed bench for axi_wr_route_scheduler: vector table plus hand-written multi-cycle sequences.
module tb_axi_wr_route_scheduler;

    logic        clk;
    logic        rstn;
    logic [3:0]  m_awvalid;
    logic [11:0] m_aw_slave;
    logic        bus_awready;
    logic        aw_grant_valid;
    logic [1:0]  aw_master_sel;
    logic [2:0]  aw_slave_sel;
    logic        bus_wvalid;
    logic        bus_wready;
    logic        bus_wlast;
    logic        w_route_valid;
    logic [1:0]  wr_data_master_sel;
    logic [2:0]  wr_data_slave_sel;
    logic [2:0]  outstanding;
    logic        w_orphan_err;

    int n_chk;
    int n_fail;

    axi_wr_route_scheduler #(
        .M_WIDTH (2),
        .S_WIDTH (3),
        .DEPTH   (4)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .m_awvalid          (m_awvalid),
        .m_aw_slave         (m_aw_slave),
        .bus_awready        (bus_awready),
        .aw_grant_valid     (aw_grant_valid),
        .aw_master_sel      (aw_master_sel),
        .aw_slave_sel       (aw_slave_sel),
        .bus_wvalid         (bus_wvalid),
        .bus_wready         (bus_wready),
        .bus_wlast          (bus_wlast),
        .w_route_valid      (w_route_valid),
        .wr_data_master_sel (wr_data_master_sel),
        .wr_data_slave_sel  (wr_data_slave_sel),
        .outstanding        (outstanding),
        .w_orphan_err       (w_orphan_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  awv;
        logic [11:0] aws;
        logic        awr;
        logic        wv;
        logic        wr;
        logic        wl;
        logic        gv;
        logic [1:0]  ms;
        logic [2:0]  ss;
        logic        wrv;
        logic [1:0]  wm;
        logic [2:0]  ws;
        logic [2:0]  outn;
        logic        orph;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] awv, input logic [11:0] aws, input logic awr,
                                input logic wv, input logic wr, input logic wl,
                                input logic gv, input logic [1:0] ms, input logic [2:0] ss,
                                input logic wrv, input logic [1:0] wm, input logic [2:0] ws,
                                input logic [2:0] outn, input logic orph);
        vec_t v;
        v.awv = awv; v.aws = aws; v.awr = awr;
        v.wv = wv; v.wr = wr; v.wl = wl;
        v.gv = gv; v.ms = ms; v.ss = ss;
        v.wrv = wrv; v.wm = wm; v.ws = ws;
        v.outn = outn; v.orph = orph;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input logic v, input logic r, input logic l);
        bus_wvalid = v;
        bus_wready = r;
        bus_wlast  = l;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " grant_valid"}, 32'(aw_grant_valid), 0);
        chk({tag, " aw_master_sel"}, 32'(aw_master_sel), 0);
        chk({tag, " aw_slave_sel"}, 32'(aw_slave_sel), 0);
        chk({tag, " w_route_valid"}, 32'(w_route_valid), 0);
        chk({tag, " wr_data_master_sel"}, 32'(wr_data_master_sel), 0);
        chk({tag, " wr_data_slave_sel"}, 32'(wr_data_slave_sel), 0);
        chk({tag, " outstanding"}, 32'(outstanding), 0);
        chk({tag, " w_orphan_err"}, 32'(w_orphan_err), 0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rstn        = 1'b0;
        m_awvalid   = '0;
        m_aw_slave  = '0;
        bus_awready = 1'b0;
        set_w(1'b0, 1'b0, 1'b0);

        // Single burst m2->s5, 4 W beats with one stall.
        vecs.push_back(mk(4'b0100, 12'h140, 0, 0, 0, 0, 1, 2, 5, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0100, 12'h140, 1, 0, 0, 0, 0, 2, 5, 1, 2, 5, 1, 0));
        vecs.push_back(mk(4'b0000, 12'h000, 0, 1, 1, 0, 0, 0, 0, 1, 2, 5, 1, 0));
        vecs.push_back(mk(4'b0000, 12'h000, 0, 1, 1, 0, 0, 0, 0, 1, 2, 5, 1, 0));
        vecs.push_back(mk(4'b0000, 12'h000, 0, 1, 0, 0, 0, 0, 0, 1, 2, 5, 1, 0));
        vecs.push_back(mk(4'b0000, 12'h000, 0, 1, 1, 0, 0, 0, 0, 1, 2, 5, 1, 0));
        vecs.push_back(mk(4'b0000, 12'h000, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        // Ordering: m1->s3 then m0->s6, completed in order.
        vecs.push_back(mk(4'b0010, 12'h018, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0010, 12'h018, 1, 0, 0, 0, 0, 1, 3, 1, 1, 3, 1, 0));
        vecs.push_back(mk(4'b0001, 12'h006, 0, 0, 0, 0, 1, 0, 6, 1, 1, 3, 1, 0));
        vecs.push_back(mk(4'b0001, 12'h006, 1, 0, 0, 0, 0, 0, 6, 1, 1, 3, 2, 0));
        vecs.push_back(mk(4'b0000, 12'h000, 0, 1, 1, 1, 0, 0, 0, 1, 0, 6, 1, 0));
        vecs.push_back(mk(4'b0000, 12'h000, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        // Orphan WLAST handshake with empty queue.
        vecs.push_back(mk(4'b0000, 12'h000, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'b0000, 12'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Build two routes, then push the third while popping the head.
        vecs.push_back(mk(4'b0100, 12'h040, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'b0100, 12'h040, 1, 0, 0, 0, 0, 2, 1, 1, 2, 1, 1, 0));
        vecs.push_back(mk(4'b1000, 12'hE00, 0, 0, 0, 0, 1, 3, 7, 1, 2, 1, 1, 0));
        vecs.push_back(mk(4'b1000, 12'hE00, 1, 0, 0, 0, 0, 3, 7, 1, 2, 1, 2, 0));
        vecs.push_back(mk(4'b0010, 12'h020, 0, 0, 0, 0, 1, 1, 4, 1, 2, 1, 2, 0));
        vecs.push_back(mk(4'b0010, 12'h020, 1, 1, 1, 1, 0, 1, 4, 1, 3, 7, 2, 0));
        vecs.push_back(mk(4'b0000, 12'h000, 0, 1, 1, 1, 0, 0, 0, 1, 1, 4, 1, 0));
        vecs.push_back(mk(4'b0000, 12'h000, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));

        #12;
        chk_all_zero("reset");
        rstn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            m_awvalid   = vecs[i].awv;
            m_aw_slave  = vecs[i].aws;
            bus_awready = vecs[i].awr;
            set_w(vecs[i].wv, vecs[i].wr, vecs[i].wl);
            tick();
            $display("vec %0d: gv=%0b m=%0d s=%0d wrv=%0b head=%0d/%0d out=%0d orph=%0b", i,
                     aw_grant_valid, aw_master_sel, aw_slave_sel, w_route_valid,
                     wr_data_master_sel, wr_data_slave_sel, outstanding, w_orphan_err);
            chk($sformatf("vec%0d grant_valid", i), 32'(aw_grant_valid), 32'(vecs[i].gv));
            chk($sformatf("vec%0d outstanding", i), 32'(outstanding), 32'(vecs[i].outn));
            chk($sformatf("vec%0d w_route_valid", i), 32'(w_route_valid), 32'(vecs[i].wrv));
            chk($sformatf("vec%0d w_orphan_err", i), 32'(w_orphan_err), 32'(vecs[i].orph));
            if (vecs[i].gv) begin
                chk($sformatf("vec%0d aw_master_sel", i), 32'(aw_master_sel), 32'(vecs[i].ms));
                chk($sformatf("vec%0d aw_slave_sel", i), 32'(aw_slave_sel), 32'(vecs[i].ss));
            end
            if (vecs[i].wrv) begin
                chk($sformatf("vec%0d wr_data_master_sel", i), 32'(wr_data_master_sel), 32'(vecs[i].wm));
                chk($sformatf("vec%0d wr_data_slave_sel", i), 32'(wr_data_slave_sel), 32'(vecs[i].ws));
            end
        end

        // All four masters request continuously: RR order from a fresh reset, stop when full.
        set_w(1'b0, 1'b0, 1'b0);
        m_awvalid   = '0;
        bus_awready = 1'b0;
        rstn        = 1'b0;
        #2;
        rstn        = 1'b1;
        m_awvalid   = 4'b1111;
        m_aw_slave  = {3'd4, 3'd3, 3'd2, 3'd1};
        bus_awready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            tick();
            $display("rr grant %0d: gv=%0b m=%0d s=%0d", g, aw_grant_valid, aw_master_sel, aw_slave_sel);
            chk($sformatf("rr%0d grant_valid", g), 32'(aw_grant_valid), 1);
            chk($sformatf("rr%0d aw_master_sel", g), 32'(aw_master_sel), 32'(g));
            chk($sformatf("rr%0d aw_slave_sel", g), 32'(aw_slave_sel), 32'(g + 1));
            tick();
            chk($sformatf("rr%0d accept gv", g), 32'(aw_grant_valid), 0);
            chk($sformatf("rr%0d outstanding", g), 32'(outstanding), 32'(g + 1));
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            $display("full hold %0d: gv=%0b out=%0d", c, aw_grant_valid, outstanding);
            chk($sformatf("full%0d grant_valid", c), 32'(aw_grant_valid), 0);
            chk($sformatf("full%0d outstanding", c), 32'(outstanding), 4);
        end
        chk("full head master", 32'(wr_data_master_sel), 0);
        chk("full head slave", 32'(wr_data_slave_sel), 1);

        set_w(1'b1, 1'b1, 1'b1);
        tick();
        set_w(1'b0, 1'b0, 1'b0);
        $display("pop at full: gv=%0b out=%0d head=%0d", aw_grant_valid, outstanding, wr_data_master_sel);
        chk("pop-at-full outstanding", 32'(outstanding), 3);
        chk("pop-at-full grant_valid", 32'(aw_grant_valid), 0);
        chk("pop-at-full head master", 32'(wr_data_master_sel), 1);
        tick();
        $display("resume grant: gv=%0b m=%0d", aw_grant_valid, aw_master_sel);
        chk("resume grant_valid", 32'(aw_grant_valid), 1);
        chk("resume aw_master_sel", 32'(aw_master_sel), 0);
        tick();
        chk("refill outstanding", 32'(outstanding), 4);
        tick();
        chk("refill no grant", 32'(aw_grant_valid), 0);

        // Async reset in GRANT with three routes queued.
        bus_awready = 1'b0;
        set_w(1'b1, 1'b1, 1'b1);
        tick();
        set_w(1'b0, 1'b0, 1'b0);
        chk("pre-reset outstanding", 32'(outstanding), 3);
        tick();
        $display("pre-reset grant: gv=%0b m=%0d out=%0d", aw_grant_valid, aw_master_sel, outstanding);
        chk("pre-reset grant_valid", 32'(aw_grant_valid), 1);
        chk("pre-reset aw_master_sel", 32'(aw_master_sel), 1);
        #2;
        rstn = 1'b0;
        #1;
        $display("async reset: gv=%0b out=%0d wrv=%0b", aw_grant_valid, outstanding, w_route_valid);
        chk_all_zero("async reset");
        tick();
        chk("reset held grant_valid", 32'(aw_grant_valid), 0);
        #2;
        rstn = 1'b1;
        tick();
        $display("post-reset grant: gv=%0b m=%0d", aw_grant_valid, aw_master_sel);
        chk("post-reset grant_valid", 32'(aw_grant_valid), 1);
        chk("post-reset aw_master_sel", 32'(aw_master_sel), 0);
        chk("post-reset outstanding", 32'(outstanding), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
